// File: rtl/req_rsp_responder.sv
// Fixed-latency responder: each accepted request reappears as a registered
// response exactly L edges later, fully pipelined, with flush and config checks.
module req_rsp_responder #(
  parameter int MAX_LAT = 8,
  parameter int DW      = 8,
  parameter int CW      = $clog2(MAX_LAT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CW-1:0] lat_cfg,
  input  logic          req,
  input  logic [DW-1:0] req_data,
  input  logic          flush,
  output logic          rsp,
  output logic [DW-1:0] rsp_data,
  output logic [CW-1:0] outstanding,
  output logic          busy,
  output logic          cfg_err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] lat_q, lat_d;
  logic [CW-1:0] out_q, out_d;
  logic          cfg_err_q, cfg_err_d;
  logic          rsp_q, rsp_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic [MAX_LAT-1:0] vld_q, vld_d;
  logic [DW-1:0] dat_q [MAX_LAT];
  logic [DW-1:0] dat_d [MAX_LAT];

  logic          lat_bad;
  logic [CW-1:0] lat_clamped;
  logic [CW-1:0] lat_eff;
  logic          accept;
  logic          direct;

  assign lat_bad     = (lat_cfg == '0) || (lat_cfg > CW'(MAX_LAT));
  assign lat_clamped = (lat_cfg == '0) ? CW'(1) :
                       (lat_cfg > CW'(MAX_LAT)) ? CW'(MAX_LAT) : lat_cfg;
  // Latency is only re-sampled when nothing is in flight, so all slots share one L.
  assign lat_eff     = (out_q == '0) ? lat_clamped : lat_q;
  assign accept      = req && !flush && (state_q != S_FLUSH);
  assign direct      = accept && (lat_eff == CW'(1));

  // Slot k holds a request that reaches the response register in k+1 edges.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_LAT; gi++) begin : g_slot
      logic ins;
      assign ins = accept && (32'(lat_eff) == gi + 2);
      if (gi == MAX_LAT - 1) begin : g_top
        assign vld_d[gi] = !flush && ins;
        assign dat_d[gi] = ins ? req_data : '0;
      end else begin : g_mid
        assign vld_d[gi] = !flush && (ins || vld_q[gi+1]);
        assign dat_d[gi] = ins ? req_data : dat_q[gi+1];
      end
    end
  endgenerate

  always_comb begin
    rsp_d      = !flush && (direct || vld_q[0]);
    rsp_data_d = rsp_data_q;
    if (rsp_d) rsp_data_d = direct ? req_data : dat_q[0];

    out_d = flush ? '0 : (out_q + CW'(accept) - CW'(rsp_q));
    lat_d = (out_q == '0) ? lat_clamped : lat_q;

    cfg_err_d = cfg_err_q;
    if (flush) begin
      cfg_err_d = 1'b0;
    end else begin
      if ((state_q == S_IDLE) && lat_bad) cfg_err_d = 1'b1;
      if ((out_q != '0) && (lat_cfg != lat_q)) cfg_err_d = 1'b1;
    end

    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (flush)    state_d = S_FLUSH;
        else if (req) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (flush)              state_d = S_FLUSH;
        else if (out_d == '0)   state_d = S_IDLE;
      end
      S_FLUSH: state_d = flush ? S_FLUSH : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      lat_q      <= CW'(1);
      out_q      <= '0;
      cfg_err_q  <= 1'b0;
      rsp_q      <= 1'b0;
      rsp_data_q <= '0;
      vld_q      <= '0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      out_q      <= out_d;
      cfg_err_q  <= cfg_err_d;
      rsp_q      <= rsp_d;
      rsp_data_q <= rsp_data_d;
      vld_q      <= vld_d;
    end
  end

  // Payloads are qualified by vld_q, so they need no reset.
  always_ff @(posedge clk) begin
    dat_q <= dat_d;
  end

  assign rsp         = rsp_q;
  assign rsp_data    = rsp_data_q;
  assign outstanding = out_q;
  assign busy        = (state_q != S_IDLE);
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_req_rsp_responder.sv
// Scoreboard bench for req_rsp_responder: a timestamp-based reference model
// predicts each response edge; a negedge monitor compares what the DUT shows.
module tb_req_rsp_responder;

  localparam int MAX_LAT = 8;
  localparam int DW      = 8;
  localparam int CW      = $clog2(MAX_LAT + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] lat_cfg = '0;
  logic          req = 1'b0;
  logic [DW-1:0] req_data = '0;
  logic          flush = 1'b0;
  logic          rsp;
  logic [DW-1:0] rsp_data;
  logic [CW-1:0] outstanding;
  logic          busy;
  logic          cfg_err;

  req_rsp_responder #(.MAX_LAT(MAX_LAT), .DW(DW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .lat_cfg(lat_cfg), .req(req), .req_data(req_data),
    .flush(flush), .rsp(rsp), .rsp_data(rsp_data), .outstanding(outstanding),
    .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb_q[$];      // expected responses, consumed by the monitor
  int   live_q[$];    // due edges of requests still counted as outstanding
  int   edge_n = 0;
  int   lat_m = 1;
  logic flush_prev = 1'b0;
  int   exp_out = 0;
  logic exp_busy = 1'b0;
  logic exp_err = 1'b0;
  int   checks = 0;
  int   errors = 0;

  function automatic int clamp_lat(input int l);
    if (l == 0) return 1;
    if (l > MAX_LAT) return MAX_LAT;
    return l;
  endfunction

  task automatic model_update();
    int   out_before;
    exp_t e;
    edge_n++;
    if (!rst_n) return;
    out_before = live_q.size();
    if (flush) begin
      live_q.delete();
      while (sb_q.size() > 0 && sb_q[$].due > edge_n) void'(sb_q.pop_back());
      exp_err = 1'b0;
    end else begin
      if (out_before == 0 && !flush_prev && (lat_cfg == 0 || int'(lat_cfg) > MAX_LAT))
        exp_err = 1'b1;
      if (out_before > 0 && int'(lat_cfg) != lat_m) exp_err = 1'b1;
    end
    if (out_before == 0) lat_m = clamp_lat(int'(lat_cfg));
    if (req && !flush && !flush_prev) begin
      e.due  = edge_n + lat_m;
      e.data = req_data;
      sb_q.push_back(e);
      live_q.push_back(e.due);
    end
    while (live_q.size() > 0 && live_q[0] <= edge_n) void'(live_q.pop_front());
    flush_prev = flush;
    exp_out  = live_q.size();
    exp_busy = (exp_out > 0) || flush_prev;
  endtask

  task automatic step(input logic r, input logic [DW-1:0] d, input int l, input logic f);
    req      = r;
    req_data = d;
    lat_cfg  = CW'(l);
    flush    = f;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle(input int n, input int l);
    for (int i = 0; i < n; i++) step(1'b0, '0, l, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    checks += 5;
    if (rsp !== 1'b0) begin errors++; $display("FAIL %s rsp got=%b exp=0", tag, rsp); end
    if (rsp_data !== '0) begin errors++; $display("FAIL %s rsp_data got=%02h exp=00", tag, rsp_data); end
    if (outstanding !== '0) begin errors++; $display("FAIL %s outstanding got=%0d exp=0", tag, outstanding); end
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy got=%b exp=0", tag, busy); end
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL %s cfg_err got=%b exp=0", tag, cfg_err); end
  endtask

  // Monitor: output visible after edge n is sampled by the consumer at edge n+1.
  logic exp_rsp;
  always @(negedge clk) begin
    exp_rsp = (sb_q.size() > 0) && (sb_q[0].due == edge_n + 1);
    checks++;
    if (rsp !== exp_rsp) begin
      errors++;
      $display("FAIL rsp edge=%0d got=%b exp=%b", edge_n + 1, rsp, exp_rsp);
    end
    if (exp_rsp) begin
      if (rsp === 1'b1) begin
        checks++;
        if (rsp_data !== sb_q[0].data) begin
          errors++;
          $display("FAIL rsp_data edge=%0d got=%02h exp=%02h", edge_n + 1, rsp_data, sb_q[0].data);
        end else begin
          $display("RSP edge=%0d data=%02h", edge_n + 1, rsp_data);
        end
      end
      void'(sb_q.pop_front());
    end
    checks += 3;
    if (int'(outstanding) != exp_out) begin
      errors++;
      $display("FAIL outstanding edge=%0d got=%0d exp=%0d", edge_n + 1, outstanding, exp_out);
    end
    if (busy !== exp_busy) begin
      errors++;
      $display("FAIL busy edge=%0d got=%b exp=%b", edge_n + 1, busy, exp_busy);
    end
    if (cfg_err !== exp_err) begin
      errors++;
      $display("FAIL cfg_err edge=%0d got=%b exp=%b", edge_n + 1, cfg_err, exp_err);
    end
  end

  initial begin
    int cur_lat;
    #1;
    check_reset_outputs("reset");
    step(1'b0, '0, 4, 1'b0);
    step(1'b0, '0, 4, 1'b0);
    rst_n = 1'b1;
    idle(4, 4);

    // single request, then a spaced second one
    step(1'b1, 8'hA5, 4, 1'b0);
    idle(10, 4);
    step(1'b1, 8'h3C, 4, 1'b0);
    idle(8, 4);

    // back-to-back with L=3
    for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 3, 1'b0);
    idle(6, 3);

    // latency change while two requests are in flight
    step(1'b1, 8'h11, 4, 1'b0);
    step(1'b1, 8'h22, 4, 1'b0);
    idle(6, 2);
    step(1'b1, 8'h33, 2, 1'b0);
    idle(4, 2);

    // out-of-range latency then flush with three in flight
    step(1'b1, 8'h44, 0, 1'b0);
    idle(3, 0);
    step(1'b1, 8'h55, 6, 1'b0);
    step(1'b1, 8'h66, 6, 1'b0);
    step(1'b1, 8'h77, 6, 1'b0);
    step(1'b0, '0, 6, 1'b1);
    idle(8, 6);

    // flush with a simultaneous request, and a request during FLUSH
    step(1'b1, 8'h88, 5, 1'b1);
    step(1'b1, 8'h99, 5, 1'b0);
    idle(6, 5);

    // asynchronous reset with two requests in flight
    step(1'b1, 8'hAA, 5, 1'b0);
    step(1'b1, 8'hBB, 5, 1'b0);
    req = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    sb_q.delete();
    live_q.delete();
    lat_m = 1; flush_prev = 1'b0; exp_out = 0; exp_busy = 1'b0; exp_err = 1'b0;
    #2;
    rst_n = 1'b1;
    idle(8, 5);

    // randomized traffic
    cur_lat = 4;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) cur_lat = $urandom_range(0, 10);
      step(1'($urandom_range(0, 1)), 8'($urandom), cur_lat, ($urandom_range(0, 49) == 0));
    end
    idle(12, cur_lat);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending got=%0d exp=0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
